// File: rtl/float2int_seq.sv
// Decodes a packed {exp, man} mini-float into its unsigned integer, shifting one bit per cycle.
// Result appears 1 + max(exp-1, 0) edges after acceptance and is held while out_ready is low.
module float2int_seq #(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4,
  parameter int INT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_man,
  output logic              in_ready,
  output logic              out_valid,
  output logic [INT_W-1:0]  out_int,
  input  logic              out_ready
);

  localparam logic [EXP_W-1:0] CNT_ONE = EXP_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [INT_W-1:0]   acc, acc_nxt;
  logic [INT_W-1:0]   out_int_nxt;
  logic [EXP_W-1:0]   cnt, cnt_nxt;
  logic               in_ready_nxt;
  logic               out_valid_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_int   <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_int   <= out_int_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    out_int_nxt   = out_int;
    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          in_ready_nxt = 1'b0;
          if (in_exp == '0) begin
            acc_nxt   = {{(INT_W-MANT_W){1'b0}}, in_man};
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            // Restore the implicit leading one of a normalised value.
            acc_nxt   = {{(INT_W-MANT_W-1){1'b0}}, 1'b1, in_man};
            cnt_nxt   = in_exp - CNT_ONE;
            state_nxt = (in_exp == CNT_ONE) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_nxt = acc << 1;
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // First DONE cycle publishes acc; out_ready only counts once out_valid is up.
        if (!out_valid) begin
          out_valid_nxt = 1'b1;
          out_int_nxt   = acc;
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_float2int_seq.sv
// Randomised bench for float2int_seq against a value/re-encode reference model.
module tb_float2int_seq;

  localparam int EXP_W  = 3;
  localparam int MANT_W = 4;
  localparam int INT_W  = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [EXP_W-1:0]  in_exp = '0;
  logic [MANT_W-1:0] in_man = '0;
  logic              in_ready;
  logic              out_valid;
  logic [INT_W-1:0]  out_int;
  logic              out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  float2int_seq #(.EXP_W(EXP_W), .MANT_W(MANT_W), .INT_W(INT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_exp(in_exp), .in_man(in_man),
    .in_ready(in_ready), .out_valid(out_valid), .out_int(out_int), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: value a {exp, man} pair denotes.
  function automatic int model_value(input int e, input int m);
    if (e == 0) return m;
    return (16 + m) * (1 << (e - 1));
  endfunction

  // Reference int2float encoder: leading one position picks the exponent.
  task automatic encode(input int v, output int e, output int m);
    int p;
    if (v < 16) begin
      e = 0;
      m = v;
    end else begin
      p = 0;
      for (int i = 0; i < 31; i++) if (v >= (1 << i)) p = i;
      e = p - 3;
      m = (v >> (p - 4)) & 15;
    end
  endtask

  task automatic convert(input int e, input int m, input int stall);
    int t_acc, t_out, exp_v, n, re_e, re_m;
    bit seen;
    exp_v = model_value(e, m);
    n = (e > 0) ? e - 1 : 0;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL conv_ready e=%0d m=%0d: in_ready=%b want 1", e, m, in_ready);
    end
    in_valid = 1'b1;
    in_exp = 3'(e);
    in_man = 4'(m);
    tick();
    t_acc = cyc;
    in_valid = 1'b0;
    in_exp = 3'($urandom);
    in_man = 4'($urandom);
    seen = 1'b0;
    t_out = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        t_out = cyc;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || (t_out - t_acc) != n + 1) begin
      errors++;
      $display("FAIL conv_latency e=%0d m=%0d: seen=%0d latency=%0d want %0d", e, m, seen, t_out - t_acc, n + 1);
    end
    checks++;
    if (out_int !== INT_W'(exp_v)) begin
      errors++;
      $display("FAIL conv_value e=%0d m=%0d: out_int=%0d want %0d", e, m, out_int, exp_v);
    end
    encode(int'(out_int), re_e, re_m);
    checks++;
    if (re_e != e || re_m != m) begin
      errors++;
      $display("FAIL conv_reencode e=%0d m=%0d: got e=%0d m=%0d", e, m, re_e, re_m);
    end
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_int !== INT_W'(exp_v)) begin
        errors++;
        $display("FAIL conv_stall e=%0d m=%0d: out_valid=%b out_int=%0d want 1/%0d", e, m, out_valid, out_int, exp_v);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL conv_release e=%0d m=%0d: out_valid=%b in_ready=%b want 0/1", e, m, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    bit bad;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_exp = 3'd1;
    in_man = 4'd3;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_int !== '0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_int=%0d want 0/0/0", in_ready, out_valid, out_int);
    end
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_no_accept: out_valid=1 want 0 (word offered during reset)");
    end
  endtask

  task automatic test_basic;
    convert(0, 9, 0);
    convert(0, 0, 1);
    convert(7, 15, 2);
    convert(1, 0, 0);
  endtask

  task automatic test_backpressure;
    int exp_v;
    bit seen, bad;
    exp_v = model_value(3, 5);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    in_valid = 1'b1;
    in_exp = 3'd3;
    in_man = 4'd5;
    tick();
    in_exp = 3'd0;
    in_man = 4'd7;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_valid: out_valid never rose");
    end
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_int !== INT_W'(exp_v) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b out_int=%0d in_ready=%b want 1/%0d/0", i, out_valid, out_int, in_ready, exp_v);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_not_queued: out_valid=1 want 0");
    end
  endtask

  task automatic test_reset_mid_shift;
    bit bad;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    in_valid = 1'b1;
    in_exp = 3'd6;
    in_man = 4'($urandom);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_int !== '0) begin
        errors++;
        $display("FAIL midrst_values cycle %0d: in_ready=%b out_valid=%b out_int=%0d want 0/0/0", i, in_ready, out_valid, out_int);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: in_ready=%b want 1", in_ready);
    end
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || out_int !== '0) begin
      errors++;
      $display("FAIL midrst_no_result: out_valid_seen=%0d out_int=%0d want 0/0", bad, out_int);
    end
  endtask

  task automatic test_roundtrip;
    int codes[128];
    int j, t;
    for (int i = 0; i < 128; i++) codes[i] = i;
    for (int i = 127; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = codes[i];
      codes[i] = codes[j];
      codes[j] = t;
    end
    for (int i = 0; i < 128; i++) convert(codes[i] >> 4, codes[i] & 15, int'($urandom_range(0, 3)));
  endtask

  task automatic test_back_to_back(input int e);
    int q[$];
    int accepts, t0, t1, m, want;
    bit acc_now;
    accepts = 0;
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    out_ready = 1'b1;
    m = int'($urandom_range(0, 15));
    in_valid = 1'b1;
    in_exp = 3'(e);
    in_man = 4'(m);
    for (int i = 0; i < 60; i++) begin
      acc_now = in_valid && in_ready;
      tick();
      if (out_valid === 1'b1) begin
        checks++;
        want = (q.size() > 0) ? q.pop_front() : -1;
        if (out_int !== INT_W'(want) || want < 0) begin
          errors++;
          $display("FAIL b2b_value e=%0d: out_int=%0d want %0d", e, out_int, want);
        end
      end
      if (acc_now) begin
        q.push_back(model_value(e, m));
        accepts++;
        if (accepts == 1) t0 = cyc;
        else t1 = cyc;
        if (accepts == 2) in_valid = 1'b0;
        else begin
          m = int'($urandom_range(0, 15));
          in_man = 4'(m);
        end
      end
      if (accepts == 2 && q.size() == 0) break;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (accepts != 2 || q.size() != 0 || (t1 - t0) != ((e > 0) ? e - 1 : 0) + 3) begin
      errors++;
      $display("FAIL b2b_interval e=%0d: accepts=%0d pending=%0d interval=%0d want 2/0/%0d",
               e, accepts, q.size(), t1 - t0, ((e > 0) ? e - 1 : 0) + 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_shift();
    test_roundtrip();
    for (int e = 0; e < 8; e++) test_back_to_back(e);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float2int_seq.md
# float2int_seq

Sequential float-to-integer decoder, the inverse of the `int2float` benchmark converter. It takes a packed 7-bit mini-float (3-bit exponent, 4-bit mantissa) and reconstructs the 11-bit unsigned integer it represents. It uses an iterative one-bit-per-cycle shifter behind valid/ready handshakes on both sides. It sits in the ALS benchmark datapath as the decode stage that closes the `int2float` round trip.

## Interface
Parameters:
- `EXP_W`, 3: exponent width.
- `MANT_W`, 4: mantissa width.
- `INT_W`, 11: output integer width. Must be at least `2**EXP_W - 2 + MANT_W + 1`; with the defaults that is 6 + 5 = 11.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  input word present.
- `in_exp`  in  EXP_W  exponent field (`out1` of `int2float`).
- `in_man`  in  MANT_W  mantissa field (`out0` of `int2float`).
- `in_ready`  out  1  block can accept a word; registered.
- `out_valid`  out  1  `out_int` holds a result; registered.
- `out_int`  out  INT_W  decoded integer; registered.
- `out_ready`  in  1  downstream accepts the result.

## Operation
Value encoding:
- `exp == 0`: value = `man`, covering 0..15.
- `exp >= 1`: value = `{1'b1, man} << (exp - 1)`, covering 16..1984.
- The encoding is continuous across `exp` 0→1. Truncated low bits are reconstructed as 0.

FSM states are IDLE, SHIFT and DONE, with a shift accumulator `acc` (INT_W bits) and a counter `cnt` (EXP_W bits).

- **IDLE** (`in_ready` = 1): on `in_valid & in_ready`:
  - `exp == 0`: `acc = man`, go to DONE.
  - Otherwise: `acc = {1, man}` zero-extended, `cnt = exp - 1`.
    - `cnt == 0`: go to DONE.
    - `cnt != 0`: go to SHIFT.
- **SHIFT** (`in_ready` = 0, `out_valid` = 0): each cycle `acc <<= 1` and `cnt -= 1`. The shift that makes `cnt` reach 0 moves the FSM to DONE.
- **DONE**: `out_valid` = 1 and `out_int = acc`.
  - On `out_ready` the FSM returns to IDLE and `out_valid` drops on that edge.
  - `out_int` holds its last value until the next result.
- One conversion is in flight at a time. Inputs are ignored outside IDLE.
- Arithmetic never overflows within legal parameters. `acc` bits above INT_W do not exist, because the maximum shift lands the MSB at bit INT_W-1.

## Timing
Reset values (any cycle with `rst_n` = 0):
- state = IDLE, `in_ready` = 0, `out_valid` = 0, `out_int` = 0, `acc` = 0, `cnt` = 0.
- `in_ready` rises at the first edge with `rst_n` = 1. No handshake is honoured during reset.

Latency, measured from the accepting edge T to the edge that raises `out_valid`:
- The edge that raises `out_valid` is T + 1 + n, with n = max(`exp` - 1, 0). This gives 1 cycle for `exp` 0 or 1 and 7 cycles for `exp` 7.
- After the `out_ready` handshake edge, `in_ready` is 1 in the next cycle. Minimum issue interval is n + 3 cycles.

Handshake rules:
- Inputs are sampled only on the accepting edge; `in_exp`/`in_man` may change afterwards.
- `out_valid`/`out_int` stay stable while `out_ready` = 0, with no limit on stall length.
- `out_ready` high in IDLE or SHIFT has no effect.
- `in_valid` high in SHIFT or DONE is not accepted and not queued.

Reset mid-operation: `rst_n` low in SHIFT or DONE aborts the conversion. All outputs return to their reset values on that edge and no `out_valid` pulse follows.

Simultaneous events: a handshake edge coinciding with `rst_n` low loses to reset.

## Test plan
- Reset then `exp` 0, `man` 9 → `out_valid` at T+1, `out_int` = 9. Also `exp` 0, `man` 0 → `out_int` = 0.
- `exp` 7, `man` 15 → `out_valid` at T+7, `out_int` = 1984. Also `exp` 1, `man` 0 → `out_int` = 16 at T+1.
- Back-pressure: `exp` 3, `man` 5 (→ 84) with `out_ready` = 0 for 10 cycles:
  - `out_valid` stays 1 and `out_int` stays 84.
  - `in_valid` held high is not accepted.
  - After `out_ready` pulses, `in_ready` = 1 in the next cycle.
- Reset mid-SHIFT: `exp` 6 accepted, `rst_n` low 2 cycles later → `out_valid` never rises, `out_int` = 0, `in_ready` = 0 during reset and 1 one edge after release.
- Exhaustive round trip: all 128 `{exp, man}` pairs with random `out_ready` stalls. Each `out_int` must equal the formula value, and re-encoding it through `int2float` must reproduce the same `{exp, man}`.
- Back-to-back issue with `out_ready` tied high: the measured interval equals n + 3 cycles for every exponent.
